io_port_initiator: RTL and testbench

IO_PORT_INITIATOR -- requirements
Module: io_port_initiator

---
 rtl/io_port_initiator.sv | 171 +++++++++++++++++
 tb/tb_io_port_initiator.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/io_port_initiator.sv
// CPU-to-device port initiator: turns a held CPU read/write request into a
// single device request strobe. It then waits, with a bounded wait, for the
// matching acknowledge and returns a one-cycle completion pulse.
module io_port_initiator #(
  parameter int unsigned D_WIDTH  = 34,
  parameter int unsigned PA_WIDTH = 4,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic                cpu_rd_i,
  input  logic                cpu_wr_i,
  input  logic [PA_WIDTH-1:0] cpu_addr_i,
  input  logic [D_WIDTH-1:0]  cpu_wdata_i,
  output logic [D_WIDTH-1:0]  cpu_rdata_o,
  output logic                cpu_done_o,
  output logic                cpu_timeout_o,
  output logic                stall_o,
  output logic                read_req_o,
  output logic                write_req_o,
  output logic [PA_WIDTH-1:0] read_addr_o,
  output logic [PA_WIDTH-1:0] write_addr_o,
  output logic [D_WIDTH-1:0]  dout_o,
  input  logic [D_WIDTH-1:0]  din_i,
  input  logic                read_ack_i,
  input  logic                write_ack_i
);

  // TIMEOUT is at most 255, so the wait counter fits in 8 bits
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic                op_wr_q, op_wr_d;
  logic [PA_WIDTH-1:0] addr_q, addr_d;
  logic [D_WIDTH-1:0]  wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [D_WIDTH-1:0]  rdata_q, rdata_d;
  logic                done_q, done_d;
  logic                tmo_q, tmo_d;
  logic                rreq_q, rreq_d;
  logic                wreq_q, wreq_d;
  logic [PA_WIDTH-1:0] raddr_q, raddr_d;
  logic [PA_WIDTH-1:0] waddr_q, waddr_d;
  logic [D_WIDTH-1:0]  dout_q, dout_d;
  logic                ack_match;
  logic                active_d;

  // Next state and next registered outputs; outputs are derived from the
  // upcoming state so they line up with the cycle the state is occupied
  always_comb begin
    state_d  = state_q;
    op_wr_d  = op_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    done_d   = 1'b0;
    tmo_d    = 1'b0;
    rreq_d   = 1'b0;
    wreq_d   = 1'b0;
    raddr_d  = '0;
    waddr_d  = '0;
    dout_d   = '0;
    active_d = 1'b0;

    ack_match = op_wr_q ? write_ack_i : read_ack_i;

    case (state_q)
      IDLE: begin
        if (cpu_wr_i || cpu_rd_i) begin
          op_wr_d = cpu_wr_i;
          addr_d  = cpu_addr_i;
          wdata_d = cpu_wdata_i;
          cnt_d   = '0;
          rreq_d  = ~cpu_wr_i;
          wreq_d  = cpu_wr_i;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A matching ack on the final counted cycle still completes normally
        if (ack_match) begin
          if (!op_wr_q) begin
            rdata_d = din_i;
          end
          done_d  = 1'b1;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          if (!op_wr_q) begin
            rdata_d = '1;
          end
          done_d  = 1'b1;
          tmo_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Device channel and write data only present while the access is live
    active_d = (state_d == ISSUE) || (state_d == WAIT);
    if (active_d) begin
      if (op_wr_d) begin
        waddr_d = addr_d;
        dout_d  = wdata_d;
      end else begin
        raddr_d = addr_d;
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= IDLE;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      rreq_q  <= 1'b0;
      wreq_q  <= 1'b0;
      raddr_q <= '0;
      waddr_q <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      rreq_q  <= rreq_d;
      wreq_q  <= wreq_d;
      raddr_q <= raddr_d;
      waddr_q <= waddr_d;
      dout_q  <= dout_d;
    end
  end

  // Stall is the only combinational output so the CPU holds in the request cycle
  assign stall_o = ((state_q == IDLE) && (cpu_rd_i || cpu_wr_i)) ||
                   (state_q == ISSUE) || (state_q == WAIT);

  assign cpu_rdata_o   = rdata_q;
  assign cpu_done_o    = done_q;
  assign cpu_timeout_o = tmo_q;
  assign read_req_o    = rreq_q;
  assign write_req_o   = wreq_q;
  assign read_addr_o   = raddr_q;
  assign write_addr_o  = waddr_q;
  assign dout_o        = dout_q;

endmodule

// File: tb/tb_io_port_initiator.sv
// Bench for io_port_initiator: directed scenarios plus randomized transactions.
// Expectations come from a transaction-level model: the strobe comes one cycle
// after the request. The first matching ack seen while waiting (or the timeout)
// fixes the completion cycle.
module tb_io_port_initiator;

  localparam int unsigned DW   = 34;
  localparam int unsigned AW   = 4;
  localparam int unsigned TO   = 16;
  localparam int unsigned MAXC = TO + 4;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          cpu_rd_i, cpu_wr_i;
  logic [AW-1:0] cpu_addr_i;
  logic [DW-1:0] cpu_wdata_i;
  logic [DW-1:0] cpu_rdata_o;
  logic          cpu_done_o, cpu_timeout_o, stall_o;
  logic          read_req_o, write_req_o;
  logic [AW-1:0] read_addr_o, write_addr_o;
  logic [DW-1:0] dout_o, din_i;
  logic          read_ack_i, write_ack_i;

  int            total = 0;
  int            bad = 0;
  int            strobes_obs = 0;
  int            strobes_exp = 0;
  logic [DW-1:0] rdata_m;

  always #5 clk = ~clk;

  io_port_initiator #(.D_WIDTH(DW), .PA_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_i(reset_i),
    .cpu_rd_i(cpu_rd_i), .cpu_wr_i(cpu_wr_i),
    .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_rdata_o(cpu_rdata_o), .cpu_done_o(cpu_done_o),
    .cpu_timeout_o(cpu_timeout_o), .stall_o(stall_o),
    .read_req_o(read_req_o), .write_req_o(write_req_o),
    .read_addr_o(read_addr_o), .write_addr_o(write_addr_o),
    .dout_o(dout_o), .din_i(din_i),
    .read_ack_i(read_ack_i), .write_ack_i(write_ack_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs just after the rising edge, return at the falling edge
  task automatic drive(input logic rd, input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input logic rack, input logic wack,
                       input logic [DW-1:0] din, input logic rst);
    @(posedge clk);
    #1;
    cpu_rd_i    = rd;
    cpu_wr_i    = wr;
    cpu_addr_i  = addr;
    cpu_wdata_i = wd;
    read_ack_i  = rack;
    write_ack_i = wack;
    din_i       = din;
    reset_i     = rst;
    @(negedge clk);
    if (read_req_o || write_req_o) strobes_obs++;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_stall"}, 64'(stall_o), 64'(0));
    chk({tag, "_rreq"},  64'(read_req_o), 64'(0));
    chk({tag, "_wreq"},  64'(write_req_o), 64'(0));
    chk({tag, "_raddr"}, 64'(read_addr_o), 64'(0));
    chk({tag, "_waddr"}, 64'(write_addr_o), 64'(0));
    chk({tag, "_dout"},  64'(dout_o), 64'(0));
    chk({tag, "_done"},  64'(cpu_done_o), 64'(0));
    chk({tag, "_tmo"},   64'(cpu_timeout_o), 64'(0));
    chk({tag, "_rdata"}, 64'(cpu_rdata_o), 64'(rdata_m));
  endtask

  task automatic idle_cycle(input string tag, input logic rack, input logic wack);
    drive(1'b0, 1'b0, AW'($urandom), DW'({$urandom(), $urandom()}), rack, wack,
          DW'({$urandom(), $urandom()}), 1'b0);
    chk_quiet(tag);
  endtask

  // One full access. ack_c selects the single cycle (relative to the request
  // cycle 0) carrying the matching ack; -1 means none; rnd scatters acks randomly.
  task automatic run_txn(input string tag, input logic rd, input logic wr,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int ack_c, input logic [DW-1:0] din_v, input bit rnd);
    bit            ackm[MAXC];
    logic [DW-1:0] dinv[MAXC];
    bit            wsel;
    bit            tmo;
    int            done_c;
    bit            act;
    logic          other;
    wsel = wr;
    for (int c = 0; c < int'(MAXC); c++) begin
      ackm[c] = rnd ? ($urandom_range(3) == 0) : (c == ack_c);
      dinv[c] = DW'({$urandom(), $urandom()});
    end
    if (!rnd && ack_c >= 0 && ack_c < int'(MAXC)) dinv[ack_c] = din_v;
    done_c = int'(TO) + 3;
    tmo    = 1'b1;
    for (int c = 2; c <= int'(TO) + 2; c++) begin
      if (ackm[c]) begin
        done_c = c + 1;
        tmo    = 1'b0;
        break;
      end
    end
    for (int c = 0; c <= done_c; c++) begin
      other = (c == 2) ? 1'b1 : 1'($urandom_range(1));
      if (wsel) drive(rd, wr, addr, wdata, other, ackm[c], dinv[c], 1'b0);
      else      drive(rd, wr, addr, wdata, ackm[c], other, dinv[c], 1'b0);
      if (c == done_c && !wsel) rdata_m = tmo ? '1 : dinv[c-1];
      act = (c >= 1) && (c < done_c);
      chk({tag, "_stall"}, 64'(stall_o), 64'(c < done_c));
      chk({tag, "_rreq"},  64'(read_req_o), 64'(c == 1 && !wsel));
      chk({tag, "_wreq"},  64'(write_req_o), 64'(c == 1 && wsel));
      chk({tag, "_raddr"}, 64'(read_addr_o), (act && !wsel) ? 64'(addr) : 64'(0));
      chk({tag, "_waddr"}, 64'(write_addr_o), (act && wsel) ? 64'(addr) : 64'(0));
      chk({tag, "_dout"},  64'(dout_o), (act && wsel) ? 64'(wdata) : 64'(0));
      chk({tag, "_done"},  64'(cpu_done_o), 64'(c == done_c));
      chk({tag, "_tmo"},   64'(cpu_timeout_o), 64'(c == done_c && tmo));
      chk({tag, "_rdata"}, 64'(cpu_rdata_o), 64'(rdata_m));
    end
    strobes_exp++;
  endtask

  initial begin
    logic rd, wr;
    reset_i = 1'b1; cpu_rd_i = 1'b0; cpu_wr_i = 1'b0; cpu_addr_i = '0;
    cpu_wdata_i = '0; din_i = '0; read_ack_i = 1'b0; write_ack_i = 1'b0;
    rdata_m = '0;

    // Reset state
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    chk_quiet("reset");
    idle_cycle("idle0", 1'b1, 1'b1);

    // Nominal read and write with ack one cycle after the strobe
    run_txn("rd_nom", 1'b1, 1'b0, AW'(2), '0, 2, DW'(34'h000000123), 1'b0);
    idle_cycle("rd_nom_after", 1'b0, 1'b0);
    run_txn("wr_nom", 1'b0, 1'b1, AW'(3), DW'(34'h0DEADBEEF), 2, '0, 1'b0);
    idle_cycle("wr_nom_after", 1'b0, 1'b0);

    // Read timeout, then a late ack that must be ignored
    run_txn("rd_tmo", 1'b1, 1'b0, AW'(7), '0, -1, '0, 1'b0);
    idle_cycle("late_ack", 1'b1, 1'b0);
    idle_cycle("late_ack2", 1'b0, 1'b0);

    // Both requests: write wins; wrong-type ack in WAIT does not complete
    run_txn("both", 1'b1, 1'b1, AW'(9), DW'(34'h2_5555_AAAA), 4, '0, 1'b0);
    idle_cycle("both_after", 1'b0, 1'b0);

    // Reset pulsed in the middle of WAIT
    drive(1'b1, 1'b0, AW'(5), '0, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b0, AW'(5), '0, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b0, AW'(5), '0, 1'b0, 1'b1, '0, 1'b0);
    drive(1'b1, 1'b0, AW'(5), '0, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, AW'(5), '0, 1'b0, 1'b0, '0, 1'b1);
    strobes_exp++;
    rdata_m = '0;
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, DW'(34'h1_2345_6789), 1'b0);
    chk_quiet("post_rst");
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, DW'(34'h1_2345_6789), 1'b0);
    chk_quiet("post_rst2");
    run_txn("rd_after_rst", 1'b1, 1'b0, AW'(6), '0, 3, DW'(34'h3_0F0F_0F0F), 1'b0);

    // Back-to-back: request stays high straight into the next access
    run_txn("b2b_a", 1'b1, 1'b0, AW'(1), '0, 2, DW'(34'h0_0000_0AAA), 1'b0);
    run_txn("b2b_b", 1'b1, 1'b0, AW'(4), '0, 2, DW'(34'h0_0000_0BBB), 1'b0);
    idle_cycle("b2b_after", 1'b0, 1'b0);

    // Randomized accesses with scattered acks and occasional idle gaps
    for (int i = 0; i < 40; i++) begin
      rd = 1'($urandom_range(1));
      wr = 1'($urandom_range(1));
      if (!rd && !wr) rd = 1'b1;
      run_txn("rand", rd, wr, AW'($urandom), DW'({$urandom(), $urandom()}), 0, '0, 1'b1);
      if ($urandom_range(1) == 1) idle_cycle("rand_gap", 1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    idle_cycle("final", 1'b0, 1'b0);
    chk("accesses", 64'(strobes_obs), 64'(strobes_exp));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
